// File: rtl/pipe_id_ctrl_pkg.sv
// rtl/pipe_id_ctrl_pkg.sv - MIPS decode codes and next-PC select constants shared by ID and the IF mux
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_J   = 3'd2;
    localparam logic [2:0] PC_SEL_JR  = 3'd3;
    localparam logic [2:0] PC_SEL_EPC = 3'd4;

endpackage

// File: rtl/pipe_id_ctrl_if.sv
// rtl/pipe_id_ctrl_if.sv - IF->ID and ID->EX handshake bundle around the ID stage
interface pipe_id_ctrl_if;
    logic        if_id_validto;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_allowin;
    logic        flush_if_id;
    logic [2:0]  pc_mux_sel;
    logic [25:0] imm_out;
    logic [31:0] rs_pc_out;
    logic        ex_allowin;
    logic        id_ex_validto;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    // master is the surrounding pipeline (IF producer, EX consumer)
    modport master (
        output if_id_validto, if_pc, if_instr, ex_allowin,
        input  id_allowin, flush_if_id, pc_mux_sel, imm_out, rs_pc_out,
               id_ex_validto, id_pc, id_instr
    );

    modport slave (
        input  if_id_validto, if_pc, if_instr, ex_allowin,
        output id_allowin, flush_if_id, pc_mux_sel, imm_out, rs_pc_out,
               id_ex_validto, id_pc, id_instr
    );
endinterface

// File: rtl/pipe_id_ctrl_br_cond.sv
// rtl/pipe_id_ctrl_br_cond.sv - combinational branch/jump/eret classifier for the held ID instruction
module br_cond
    import mips_defs::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_taken,
    output logic        o_is_jump,
    output logic        o_is_jr,
    output logic        o_is_eret
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_rs_neg;
    logic       w_rs_zero;

    assign w_op      = i_instr[31:26];
    assign w_rt      = i_instr[20:16];
    assign w_funct   = i_instr[5:0];
    assign w_rs_neg  = i_rs_data[31];
    assign w_rs_zero = (i_rs_data == 32'd0);

    always_comb begin
        o_taken = 1'b0;
        case (w_op)
            OP_BEQ:    o_taken = (i_rs_data == i_rt_data);
            OP_BNE:    o_taken = (i_rs_data != i_rt_data);
            OP_BLEZ:   o_taken = w_rs_neg | w_rs_zero;
            OP_BGTZ:   o_taken = !w_rs_neg && !w_rs_zero;
            OP_REGIMM: begin
                // linking variants share the condition; the link write is EX's job
                case (w_rt)
                    RT_BLTZ, RT_BLTZAL: o_taken = w_rs_neg;
                    RT_BGEZ, RT_BGEZAL: o_taken = !w_rs_neg;
                    default:            o_taken = 1'b0;
                endcase
            end
            default:   o_taken = 1'b0;
        endcase
    end

    assign o_is_jump = (w_op == OP_J) || (w_op == OP_JAL);
    assign o_is_jr   = (w_op == OP_SPECIAL) && ((w_funct == FN_JR) || (w_funct == FN_JALR));
    assign o_is_eret = (i_instr == ERET_INSTR);

endmodule

// File: rtl/pipe_id_ctrl.sv
// rtl/pipe_id_ctrl.sv - ID stage front end: IF/ID register, back-pressure, branch resolution, EX handoff
module pipe_id_ctrl
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_in,
    input  logic          flush_id,
    input  logic [31:0]   rs_data,
    input  logic [31:0]   rt_data,
    pipe_id_ctrl_if.slave bus
);

    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;

    logic        w_ready_go;
    logic        w_allowin;
    logic        w_go;
    logic        w_flush_if_id;
    logic        w_load;
    logic        w_taken;
    logic        w_is_jump;
    logic        w_is_jr;
    logic        w_is_eret;
    logic [2:0]  w_pc_sel;

    br_cond u_br_cond (
        .i_instr   (r_id_instr),
        .i_rs_data (rs_data),
        .i_rt_data (rt_data),
        .o_taken   (w_taken),
        .o_is_jump (w_is_jump),
        .o_is_jr   (w_is_jr),
        .o_is_eret (w_is_eret)
    );

    assign w_ready_go    = !stall_in;
    assign w_allowin     = !r_id_valid || (w_ready_go && bus.ex_allowin);
    assign w_go          = r_id_valid && w_ready_go && !flush_id;
    // eret has no delay slot: the sequential fetch arriving now is squashed
    assign w_flush_if_id = w_go && w_is_eret && bus.ex_allowin;
    assign w_load        = bus.if_id_validto && !w_flush_if_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= RESET_PC;
            r_id_instr <= 32'd0;
        end else if (flush_id) begin
            r_id_valid <= 1'b0;
        end else if (w_allowin) begin
            r_id_valid <= w_load;
            if (w_load) begin
                r_id_pc    <= bus.if_pc;
                r_id_instr <= bus.if_instr;
            end
        end
    end

    always_comb begin
        w_pc_sel = PC_SEL_SEQ;
        if (w_go) begin
            if (w_is_eret)      w_pc_sel = PC_SEL_EPC;
            else if (w_is_jr)   w_pc_sel = PC_SEL_JR;
            else if (w_is_jump) w_pc_sel = PC_SEL_J;
            else if (w_taken)   w_pc_sel = PC_SEL_BR;
        end
    end

    assign bus.id_allowin    = w_allowin;
    assign bus.flush_if_id   = w_flush_if_id;
    assign bus.pc_mux_sel    = w_pc_sel;
    assign bus.imm_out       = r_id_instr[25:0];
    assign bus.rs_pc_out     = rs_data;
    assign bus.id_ex_validto = w_go;
    assign bus.id_pc         = r_id_pc;
    assign bus.id_instr      = r_id_instr;

endmodule

// File: tb/tb_pipe_id_ctrl.sv
// tb/tb_pipe_id_ctrl.sv - directed-vector scoreboard bench for pipe_id_ctrl
module tb_pipe_id_ctrl;

    localparam logic [31:0] RPC  = 32'hBFC0_0000;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = 32'h1022_0003;
    localparam logic [31:0] BGTZ = 32'h1C20_0004;
    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam logic [31:0] JR   = 32'h03E0_0008;
    localparam logic [31:0] JINS = 32'h0800_0100;
    localparam logic [31:0] BLTZ = 32'h0420_0002;
    localparam logic [31:0] BGEZ = 32'h0421_0002;
    localparam logic [31:0] BLEZ = 32'h1820_0002;

    typedef struct {
        bit          chk;
        logic        rst, vld;
        logic [31:0] pc, instr;
        logic        exa, stl, fl;
        logic [31:0] rs, rt;
        logic        e_allow, e_flush, e_exv;
        logic [2:0]  e_sel;
        bit          e_chkpc;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        allow, flush, exv;
        logic [2:0]  sel;
        bit          chkpc;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, flush_id;
    logic [31:0] rs_data, rt_data;
    int          n_checks = 0;
    int          n_err = 0;
    vec_t        vecs[$];
    exp_t        sb[$];

    pipe_id_ctrl_if bus();

    pipe_id_ctrl #(.RESET_PC(RPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_in (stall_in),
        .flush_id (flush_id),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit chk, input logic r, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic exa, input logic stl, input logic fl, input logic [31:0] rs, input logic [31:0] rt,
                       input logic ea, input logic ef, input logic ev, input logic [2:0] es,
                       input bit ecp, input logic [31:0] epc);
        vec_t x;
        x.chk = chk; x.rst = r; x.vld = v; x.pc = pc; x.instr = ins;
        x.exa = exa; x.stl = stl; x.fl = fl; x.rs = rs; x.rt = rt;
        x.e_allow = ea; x.e_flush = ef; x.e_exv = ev; x.e_sel = es;
        x.e_chkpc = ecp; x.e_pc = epc;
        vecs.push_back(x);
    endtask

    // monitor: one expectation per checked cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("id_allowin", e.idx, {31'd0, bus.id_allowin}, {31'd0, e.allow});
                check("flush_if_id", e.idx, {31'd0, bus.flush_if_id}, {31'd0, e.flush});
                check("id_ex_validto", e.idx, {31'd0, bus.id_ex_validto}, {31'd0, e.exv});
                check("pc_mux_sel", e.idx, {29'd0, bus.pc_mux_sel}, {29'd0, e.sel});
                if (e.chkpc) check("id_pc", e.idx, bus.id_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; stall_in = 1'b0; flush_id = 1'b0; rs_data = '0; rt_data = '0;
        bus.if_id_validto = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.ex_allowin = 1'b1;

        // reset and first instruction
        add(0,1,0,32'h0,NOP,1,0,0,0,0,              0,0,0,3'd0,0,32'h0);
        add(1,1,0,32'h0,NOP,1,0,0,0,0,              1,0,0,3'd0,1,RPC);
        add(1,0,1,32'h10,NOP,1,0,0,0,0,             1,0,0,3'd0,1,RPC);
        add(1,0,1,32'h14,BEQ,1,0,0,0,0,             1,0,1,3'd0,1,32'h10);
        // beq taken, then not taken
        add(1,0,1,32'h18,NOP,1,0,0,5,5,             1,0,1,3'd1,1,32'h14);
        add(1,0,1,32'h1C,BEQ,1,0,0,5,5,             1,0,1,3'd0,1,32'h18);
        add(1,0,1,32'h20,NOP,1,0,0,5,6,             1,0,1,3'd0,1,32'h1C);
        // bgtz held by stall for three cycles
        add(1,0,1,32'h24,BGTZ,1,0,0,0,0,            1,0,1,3'd0,1,32'h20);
        add(1,0,1,32'h28,NOP,1,1,0,7,0,             0,0,0,3'd0,1,32'h24);
        add(1,0,1,32'h28,NOP,1,1,0,7,0,             0,0,0,3'd0,1,32'h24);
        add(1,0,1,32'h28,NOP,1,1,0,7,0,             0,0,0,3'd0,1,32'h24);
        add(1,0,1,32'h28,NOP,1,0,0,7,0,             1,0,1,3'd1,1,32'h24);
        // eret squashes the pc+4 fetch
        add(1,0,1,32'h2C,ERET,1,0,0,0,0,            1,0,1,3'd0,1,32'h28);
        add(1,0,1,32'h30,NOP,1,0,0,0,0,             1,1,1,3'd4,1,32'h2C);
        add(1,0,1,32'h100,NOP,1,0,0,0,0,            1,0,0,3'd0,0,32'h0);
        // EX back-pressure
        add(1,0,1,32'h104,NOP,0,0,0,0,0,            0,0,1,3'd0,1,32'h100);
        add(1,0,1,32'h104,NOP,0,0,0,0,0,            0,0,1,3'd0,1,32'h100);
        add(1,0,1,32'h104,NOP,1,0,0,0,0,            1,0,1,3'd0,1,32'h100);
        add(1,0,1,32'h108,JR,1,0,0,0,0,             1,0,1,3'd0,1,32'h104);
        // flush_id against a held jr
        add(1,0,1,32'h10C,NOP,1,0,1,32'h400,0,      1,0,0,3'd0,1,32'h108);
        add(1,0,1,32'h200,JR,1,0,0,0,0,             1,0,0,3'd0,0,32'h0);
        add(1,0,1,32'h204,NOP,1,0,0,32'h400,0,      1,0,1,3'd3,1,32'h200);
        add(1,0,1,32'h208,JINS,1,0,0,0,0,           1,0,1,3'd0,1,32'h204);
        add(1,0,1,32'h20C,NOP,1,0,0,0,0,            1,0,1,3'd2,1,32'h208);
        // sign-based branches at the zero/negative boundary
        add(1,0,1,32'h210,BLTZ,1,0,0,0,0,           1,0,1,3'd0,1,32'h20C);
        add(1,0,1,32'h214,NOP,1,0,0,32'h8000_0000,0,1,0,1,3'd1,1,32'h210);
        add(1,0,1,32'h218,BGEZ,1,0,0,0,0,           1,0,1,3'd0,1,32'h214);
        add(1,0,1,32'h21C,NOP,1,0,0,32'h8000_0000,0,1,0,1,3'd0,1,32'h218);
        add(1,0,1,32'h220,BLEZ,1,0,0,0,0,           1,0,1,3'd0,1,32'h21C);
        add(1,0,1,32'h224,NOP,1,0,0,0,0,            1,0,1,3'd1,1,32'h220);
        // reset + flush + stall over a held jr
        add(1,0,1,32'h300,JR,1,0,0,0,0,             1,0,1,3'd0,1,32'h224);
        add(1,1,1,32'h304,NOP,1,1,1,32'h400,0,      0,0,0,3'd0,1,32'h300);
        add(1,0,0,32'h0,NOP,1,0,0,0,0,              1,0,0,3'd0,1,RPC);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; stall_in = vecs[i].stl; flush_id = vecs[i].fl;
            rs_data = vecs[i].rs; rt_data = vecs[i].rt;
            bus.if_id_validto = vecs[i].vld; bus.if_pc = vecs[i].pc;
            bus.if_instr = vecs[i].instr; bus.ex_allowin = vecs[i].exa;
            if (vecs[i].chk) begin
                e.idx = i; e.allow = vecs[i].e_allow; e.flush = vecs[i].e_flush;
                e.exv = vecs[i].e_exv; e.sel = vecs[i].e_sel;
                e.chkpc = vecs[i].e_chkpc; e.pc = vecs[i].e_pc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", -1, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_id_ctrl.md
Name: pipe_id_ctrl

Overview:
ID-stage front end that is the consumer side of the IF→ID interface.
- Holds the IF/ID pipeline register (valid, pc, instr) and produces the id_allowin back-pressure to IF.
- Resolves branches, jumps and eret in ID and drives the next-PC select, immediate, jump-register target and flush_if_id back to IF.
- Forwards the held instruction to EX through a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into id_pc on reset; keeps id_pc deterministic while invalid.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_id_validto  in  1  IF has a valid instruction for ID this cycle.
- if_pc  in  32  PC of the IF instruction.
- if_instr  in  32  IF instruction word.
- ex_allowin  in  1  EX can accept an instruction this cycle.
- stall_in  in  1  hazard unit (load-use on rs/rt); 1 = ID not ready.
- flush_id  in  1  later-stage exception; squash ID contents.
- rs_data  in  32  forwarded GPR[rs] of the held instruction.
- rt_data  in  32  forwarded GPR[rt] of the held instruction.
- id_allowin  out  1  ID accepts the IF instruction this cycle.
- flush_if_id  out  1  IF must deliver a bubble this cycle.
- pc_mux_sel  out  3  next-PC select: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 epc.
- imm_out  out  26  id_instr[25:0], for branch offset / jump index.
- rs_pc_out  out  32  rs_data, used as the jr/jalr target.
- id_ex_validto  out  1  valid instruction handed to EX.
- id_pc  out  32  registered PC of the held instruction.
- id_instr  out  32  registered instruction word.

Behaviour:
- Reset (rst=1 at posedge): id_valid=0, id_pc=RESET_PC, id_instr=0.
  - Combinational outputs then follow: id_allowin=1, pc_mux_sel=0, flush_if_id=0, id_ex_validto=0.
- Readiness and handshake:
  - ready_go = !stall_in.
  - id_allowin = !id_valid || (ready_go && ex_allowin).
  - fire = id_valid && ready_go && ex_allowin && !flush_id.
- Register update, priority order:
  1. rst.
  2. flush_id: id_valid<=0, pc/instr don't-care.
  3. id_allowin: id_valid<=if_id_validto; pc/instr are loaded only when if_id_validto=1.
  4. Otherwise hold all state.
- id_ex_validto = id_valid && ready_go && !flush_id.
- Decode is combinational on id_instr; only the opcode/funct/rt fields are used.
  - beq (op 04): taken when rs==rt.
  - bne (05): taken when rs!=rt.
  - blez (06): taken when signed rs<=0.
  - bgtz (07): taken when signed rs>0.
  - REGIMM (01) rt=00 bltz: taken when rs<0. rt=01 bgez: taken when rs>=0. rt=10 bltzal and rt=11 bgezal use the same conditions.
  - j (02) and jal (03): unconditional.
  - SPECIAL funct 08 jr and 09 jalr: unconditional.
  - eret: COP0, instr == 32'h4200_0018.
- pc_mux_sel is non-zero only when id_valid && ready_go && !flush_id:
  - taken branch → 1; j/jal → 2; jr/jalr → 3; eret → 4; otherwise 0.
  - When ID is stalled, sel=0. IF cannot advance (id_allowin=0), so no PC is lost.
- Delay slot: branches and jumps have one delay slot.
  - IF's PC at resolution is the slot PC, and the branch target is formed from it.
  - The slot instruction is not flushed.
- eret has no delay slot. flush_if_id = id_valid && is_eret && ready_go && ex_allowin && !flush_id, so the pc+4 fetch is squashed and ID loads a bubble.
- Simultaneous events:
  - flush_id dominates every other input.
  - stall_in together with a branch gives sel=0 and no flush.
  - A reset arriving mid-stall discards the held instruction.
- Arithmetic: comparisons are 32-bit. rs<0 tests bit 31. rs<=0 is bit31 | (rs==0).

Decomposition:
- Shared package mips_defs holds:
  - opcode, funct and REGIMM rt codes;
  - the ERET encoding;
  - the PC_SEL_SEQ/BR/J/JR/EPC 3-bit constants, shared with the IF mux.
- One sub-module, br_cond: combinational condition evaluator taking (instr, rs_data, rt_data) and returning taken, is_jump, is_jr, is_eret.

Test Plan:
1. Reset, then IF validto=1, pc=0x0000_0010, instr=nop, ex_allowin=1 → next cycle id_pc=0x10, id_ex_validto=1, pc_mux_sel=0.
2. beq with rs_data=rt_data=5, no stall → pc_mux_sel=1 for one cycle, flush_if_id=0. Repeat with rt_data=6 → sel=0.
3. bgtz held with stall_in=1 for 3 cycles → id_allowin=0, sel=0, id_pc constant. stall_in→0 → sel=1 and id_allowin=1 in the same cycle.
4. eret (0x42000018) valid, ex_allowin=1 → pc_mux_sel=4 and flush_if_id=1. The next ID content is a bubble (id_ex_validto=0).
5. ex_allowin=0 with a valid instruction → id_allowin=0, the register holds, and the IF instruction is not lost once ex_allowin=1.
6. flush_id=1 concurrent with a taken jr and with rst → sel=0, id_valid=0 next cycle. rst gives id_pc=RESET_PC.
